// File: rtl/serial_tx_scheduler_pkg.sv
// Shared frame constants, FSM state codes and payload type for the serial DATA frame
// produced by the scheduler and parsed by the lever receiver.
package serial_tx_scheduler_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned WORD_W    = 16;
  localparam int unsigned FRAME_LEN = 9;
  localparam int unsigned IDX_W     = 4;

  localparam logic [BYTE_W-1:0] PRE_D = 8'h44;
  localparam logic [BYTE_W-1:0] PRE_A = 8'h41;
  localparam logic [BYTE_W-1:0] PRE_T = 8'h54;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_NEXT  = 3'd3,
    ST_ABORT = 3'd4
  } state_t;

  typedef struct packed {
    logic [BYTE_W-1:0] tag;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
  } payload_t;

  // Byte at position idx of the frame "DATA", tag, a LSB/MSB, b LSB/MSB
  function automatic logic [BYTE_W-1:0] frame_byte(input logic [IDX_W-1:0] idx,
                                                   input payload_t p);
    logic [BYTE_W-1:0] r;
    case (idx)
      4'd0:    r = PRE_D;
      4'd1:    r = PRE_A;
      4'd2:    r = PRE_T;
      4'd3:    r = PRE_A;
      4'd4:    r = p.tag;
      4'd5:    r = p.a[7:0];
      4'd6:    r = p.a[15:8];
      4'd7:    r = p.b[7:0];
      default: r = p.b[15:8];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/serial_tx_scheduler_if.sv
// Requester and UART byte-handshake bundle of the serial TX scheduler.
// master = scheduler side, slave = requesters plus UART side.
interface serial_tx_scheduler_if;
  import serial_tx_scheduler_pkg::*;

  logic [1:0]        req;
  logic [WORD_W-1:0] req0_a;
  logic [WORD_W-1:0] req0_b;
  logic [WORD_W-1:0] req1_a;
  logic [WORD_W-1:0] req1_b;
  logic [1:0]        grant;
  logic              tx_partida;
  logic [BYTE_W-1:0] tx_dados;
  logic              tx_pronto;
  logic              busy;
  logic              err_timeout;

  modport master (
    input  req, req0_a, req0_b, req1_a, req1_b, tx_pronto,
    output grant, tx_partida, tx_dados, busy, err_timeout
  );

  modport slave (
    output req, req0_a, req0_b, req1_a, req1_b, tx_pronto,
    input  grant, tx_partida, tx_dados, busy, err_timeout
  );

endinterface

// File: rtl/hexa7seg.sv
// Hex digit to 7-segment pattern, active-low, bit order {g,f,e,d,c,b,a}.
module hexa7seg (
  input  logic [3:0] hexa,
  output logic [6:0] display
);

  always_comb begin
    display = 7'b1111111;
    case (hexa)
      4'h0: display = 7'b1000000;
      4'h1: display = 7'b1111001;
      4'h2: display = 7'b0100100;
      4'h3: display = 7'b0110000;
      4'h4: display = 7'b0011001;
      4'h5: display = 7'b0010010;
      4'h6: display = 7'b0000010;
      4'h7: display = 7'b1111000;
      4'h8: display = 7'b0000000;
      4'h9: display = 7'b0010000;
      4'hA: display = 7'b0001000;
      4'hB: display = 7'b0000011;
      4'hC: display = 7'b1000110;
      4'hD: display = 7'b0100001;
      4'hE: display = 7'b0000110;
      default: display = 7'b0001110;
    endcase
  end

endmodule

// File: rtl/serial_tx_scheduler_rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins; on contention ptr selects the winner.
module serial_tx_scheduler_rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] win_c
);

  always_comb begin
    win_c = 2'b00;
    case (req)
      2'b01:   win_c = 2'b01;
      2'b10:   win_c = 2'b10;
      2'b11:   win_c = ptr ? 2'b10 : 2'b01;
      default: win_c = 2'b00;
    endcase
  end

endmodule

// File: rtl/serial_tx_scheduler.sv
// Round-robin sharing of one 8N1 UART transmitter between two requesters; each grant
// emits a 9-byte DATA frame with a per-byte watchdog that aborts a stalled frame.
module serial_tx_scheduler
  import serial_tx_scheduler_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYCLES = 100000,
  parameter logic [BYTE_W-1:0] TAG0           = 8'h30,
  parameter logic [BYTE_W-1:0] TAG1           = 8'h31
) (
  input  logic                  clock,
  input  logic                  reset,
  serial_tx_scheduler_if.master bus,
  output logic [6:0]            db_estado
);

  localparam int unsigned     WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              ptr_q, ptr_d;
  logic              served_q, served_d;
  payload_t          pay_q, pay_d;
  logic [1:0]        grant_q, grant_d;
  logic              partida_q, partida_d;
  logic [BYTE_W-1:0] dados_q, dados_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [1:0]        win_c;

  serial_tx_scheduler_rr_arbiter2 u_arb (
    .req   (bus.req),
    .ptr   (ptr_q),
    .win_c (win_c)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      wd_q      <= '0;
      ptr_q     <= 1'b0;
      served_q  <= 1'b0;
      pay_q     <= '0;
      grant_q   <= 2'b00;
      partida_q <= 1'b0;
      dados_q   <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wd_q      <= wd_d;
      ptr_q     <= ptr_d;
      served_q  <= served_d;
      pay_q     <= pay_d;
      grant_q   <= grant_d;
      partida_q <= partida_d;
      dados_q   <= dados_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  // Next state plus next value of every registered output; pulses default low
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wd_d      = wd_q;
    ptr_d     = ptr_q;
    served_d  = served_q;
    pay_d     = pay_q;
    grant_d   = 2'b00;
    partida_d = 1'b0;
    dados_d   = dados_q;
    busy_d    = busy_q;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_c != 2'b00) begin
          grant_d  = win_c;
          busy_d   = 1'b1;
          idx_d    = '0;
          served_d = win_c[1];
          pay_d    = win_c[1] ? {TAG1, bus.req1_a, bus.req1_b}
                              : {TAG0, bus.req0_a, bus.req0_b};
          state_d  = ST_START;
        end
      end
      ST_START: begin
        partida_d = 1'b1;
        dados_d   = frame_byte(idx_q, pay_q);
        wd_d      = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.tx_pronto) begin
          state_d = ST_NEXT;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          ptr_d   = ~served_q;
          state_d = ST_ABORT;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_NEXT: begin
        if (idx_q == IDX_LAST) begin
          busy_d  = 1'b0;
          ptr_d   = ~served_q;
          state_d = ST_IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_START;
        end
      end
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign bus.grant       = grant_q;
  assign bus.tx_partida  = partida_q;
  assign bus.tx_dados    = dados_q;
  assign bus.busy        = busy_q;
  assign bus.err_timeout = err_q;

  hexa7seg u_seg (
    .hexa    ({1'b0, state_q}),
    .display (db_estado)
  );

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Scoreboard bench for serial_tx_scheduler: random frames, round-robin order,
// watchdog abort, mid-frame reset and spurious tx_pronto.
module tb_serial_tx_scheduler;

  localparam int unsigned TMO = 50;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] db_estado;

  serial_tx_scheduler_if bus ();

  serial_tx_scheduler #(.TIMEOUT_CYCLES(TMO), .TAG0(8'h30), .TAG1(8'h31)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  exp_bytes[$];
  logic [1:0]  exp_grants[$];
  int          target[2]  = '{0, 0};
  int          granted[2] = '{0, 0};
  int          pronto_delay = 10;
  int          suppress_idx = -1;
  int          spur_mode = 0;
  logic        pronto_uart = 1'b0;
  logic        pronto_spur = 1'b0;
  int          exp_err = 0;
  int          seen_err = 0;
  int          cyc = 0;
  int          model_ptr = 0;
  logic [15:0] da[2] = '{16'h0, 16'h0};
  logic [15:0] dbw[2] = '{16'h0, 16'h0};

  assign bus.req       = {granted[1] < target[1], granted[0] < target[0]};
  assign bus.req0_a    = da[0];
  assign bus.req0_b    = dbw[0];
  assign bus.req1_a    = da[1];
  assign bus.req1_b    = dbw[1];
  assign bus.tx_pronto = pronto_uart | pronto_spur;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  // Reference: a frame is the literal "DATA" preamble, the tag, then a and b little-endian
  function automatic void push_frame(int who, int nbytes);
    logic [7:0] f[9];
    logic [7:0] tag;
    tag = (who == 1) ? 8'h31 : 8'h30;
    f = '{8'h44, 8'h41, 8'h54, 8'h41, tag,
          da[who][7:0], da[who][15:8], dbw[who][7:0], dbw[who][15:8]};
    exp_grants.push_back((who == 1) ? 2'b10 : 2'b01);
    for (int i = 0; i < nbytes; i++) exp_bytes.push_back(f[i]);
  endfunction

  // Reference: held requests are served alternately, a lone requester always wins
  function automatic void plan(int c0, int c1);
    int r[2];
    int w;
    r = '{c0, c1};
    while (r[0] + r[1] > 0) begin
      if (r[0] > 0 && r[1] > 0) w = model_ptr;
      else w = (r[0] > 0) ? 0 : 1;
      push_frame(w, 9);
      r[w]--;
      model_ptr = 1 - w;
    end
  endfunction

  task automatic wait_done(int budget);
    int t = 0;
    while ((exp_bytes.size() != 0 || exp_grants.size() != 0 || bus.busy ||
            seen_err != exp_err) && t < budget) begin
      @(negedge clock);
      t++;
    end
    check("drain_bytes", 32'(exp_bytes.size()), 0);
    check("drain_busy", 32'(bus.busy), 0);
    repeat (3) @(negedge clock);
  endtask

  task automatic run(int c0, int c1);
    plan(c0, c1);
    target[0] = granted[0] + c0;
    target[1] = granted[1] + c1;
    wait_done(3000 * (c0 + c1 + 1));
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a grant, a byte or an abort
  logic [7:0] held = 8'h00;
  int         part_cyc = 0;
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset) begin
        if (bus.grant != 2'b00) begin
          if (exp_grants.size() == 0) check("grant_unexpected", 32'(bus.grant), 0);
          else check("grant", 32'(bus.grant), 32'(exp_grants.pop_front()));
          if (bus.grant[0]) granted[0]++;
          if (bus.grant[1]) granted[1]++;
        end
        if (bus.tx_partida) begin
          part_cyc = cyc;
          held = bus.tx_dados;
          if (exp_bytes.size() == 0) check("partida_unexpected", 32'(bus.tx_partida), 0);
          else check("byte", 32'(bus.tx_dados), 32'(exp_bytes.pop_front()));
        end
        if (pronto_uart && bus.busy) check("dados_stable", 32'(bus.tx_dados), 32'(held));
        if (bus.err_timeout) begin
          seen_err++;
          check("timeout_latency", 32'(cyc - part_cyc), TMO);
          check("busy_at_abort", 32'(bus.busy), 0);
        end
      end
    end
  end

  // UART model: tx_pronto pronto_delay cycles after each partida, optionally dropped for one byte
  initial begin
    int k = 0;
    forever begin
      @(negedge clock);
      if (bus.grant != 2'b00) k = 0;
      if (bus.tx_partida && !reset) begin
        if (k != suppress_idx) begin
          repeat (pronto_delay - 1) @(negedge clock);
          pronto_uart = 1'b1;
          @(negedge clock);
          pronto_uart = 1'b0;
        end
        k++;
      end
    end
  end

  // Spurious tx_pronto source: mode 1 pulses while idle, mode 2 pulses in the grant (START) cycle
  initial begin
    forever begin
      @(negedge clock);
      if (spur_mode == 1 || (spur_mode == 2 && bus.grant != 2'b00)) begin
        pronto_spur = 1'b1;
        @(negedge clock);
        pronto_spur = 1'b0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clock);
    check("rst_grant", 32'(bus.grant), 0);
    check("rst_partida", 32'(bus.tx_partida), 0);
    check("rst_dados", 32'(bus.tx_dados), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_err", 32'(bus.err_timeout), 0);
    check("rst_db_estado", 32'(db_estado), 32'(7'b1000000));
    reset = 1'b0;

    // Both requesting: strict alternation starting with requester 0
    da[0] = 16'($urandom); dbw[0] = 16'($urandom);
    da[1] = 16'($urandom); dbw[1] = 16'($urandom);
    run(2, 2);

    // Directed frame
    da[0] = 16'h1234; dbw[0] = 16'hFFFE;
    run(1, 0);

    // Spurious pronto in IDLE, then in START
    spur_mode = 1;
    repeat (8) @(negedge clock);
    spur_mode = 0;
    repeat (3) @(negedge clock);
    check("idle_busy_spur", 32'(bus.busy), 0);
    spur_mode = 2;
    da[1] = 16'($urandom); dbw[1] = 16'($urandom);
    run(0, 1);
    spur_mode = 0;

    for (int it = 0; it < 6; it++) begin
      int c0, c1;
      c0 = int'($urandom_range(0, 2));
      c1 = int'($urandom_range(0, 2));
      if (c0 + c1 == 0) c0 = 1;
      pronto_delay = int'($urandom_range(1, 12));
      for (int i = 0; i < 2; i++) begin
        da[i] = 16'($urandom);
        dbw[i] = 16'($urandom);
      end
      run(c0, c1);
    end
    pronto_delay = 10;

    // Watchdog abort on byte 2, then the other requester goes first
    suppress_idx = 2;
    push_frame(0, 3);
    model_ptr = 1;
    exp_err++;
    target[0] = granted[0] + 1;
    wait_done(3000);
    suppress_idx = -1;
    check("err_count", 32'(seen_err), 32'(exp_err));
    run(1, 1);

    // Reset while byte 5 is in flight
    push_frame(0, 6);
    target[0] = granted[0] + 1;
    begin
      int t = 0;
      while (exp_bytes.size() != 0 && t < 3000) begin
        @(negedge clock);
        t++;
      end
      check("reach_byte5", 32'(exp_bytes.size()), 0);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_partida", 32'(bus.tx_partida), 0);
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_dados", 32'(bus.tx_dados), 0);
    check("mid_rst_db_estado", 32'(db_estado), 32'(7'b1000000));
    reset = 1'b0;
    model_ptr = 0;
    repeat (20) @(negedge clock);
    check("post_rst_busy", 32'(bus.busy), 0);
    run(1, 1);

    check("grants_left", 32'(exp_grants.size()), 0);
    check("err_total", 32'(seen_err), 32'(exp_err));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
